// File: rtl/generador_flancos_pkg.sv
// Shared constants for the sensor edge-count link: code values, decode thresholds, FSM states.
package generador_flancos_pkg;

    localparam logic [2:0]  CODE_LOW          = 3'd2;
    localparam logic [2:0]  CODE_MID          = 3'd3;
    localparam logic [2:0]  CODE_HIGH         = 3'd4;
    localparam int unsigned UMBRAL_1          = 15;
    localparam int unsigned UMBRAL_2          = 30;
    localparam int unsigned MAX_EDGES         = 255;
    localparam int unsigned DEF_WINDOW_CYCLES = 25_000_000;

    typedef enum logic [1:0] {StIdle, StSend, StDone} estado_t;

endpackage

// File: rtl/temporizador_ventana.sv
// Window timer: counts WINDOW_CYCLES cycles after a start pulse and flags the last one.
module temporizador_ventana #(
    parameter int unsigned WINDOW_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_active,
    output logic o_last
);

    logic [31:0] r_count;
    logic        r_active;
    logic        w_at_end;

    assign w_at_end = (r_count == 32'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_count  <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_at_end) begin
                r_count  <= '0;
                r_active <= 1'b0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign o_active = r_active;
    assign o_last   = r_active & w_at_end;

endmodule

// File: rtl/generador_flancos.sv
// Transmit side of the edge-count link: turns an accepted code into a burst of evenly
// spaced falling edges on sensor_out within one timer window.
module generador_flancos
    import generador_flancos_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned EDGES_C2      = 10,
    parameter int unsigned EDGES_C3      = 23,
    parameter int unsigned EDGES_C4      = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_code_in,
    input  logic       i_code_valid,
    output logic       o_code_ready,
    output logic       o_sensor_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_edges_sent
);

    localparam int unsigned P_C2 = (EDGES_C2 == 0) ? 0 : WINDOW_CYCLES / EDGES_C2;
    localparam int unsigned P_C3 = (EDGES_C3 == 0) ? 0 : WINDOW_CYCLES / EDGES_C3;
    localparam int unsigned P_C4 = (EDGES_C4 == 0) ? 0 : WINDOW_CYCLES / EDGES_C4;
    localparam int unsigned L_C2 = P_C2 / 2;
    localparam int unsigned L_C3 = P_C3 / 2;
    localparam int unsigned L_C4 = P_C4 / 2;

    if (EDGES_C2 < 1 || EDGES_C2 > UMBRAL_1 ||
        EDGES_C3 <= UMBRAL_1 || EDGES_C3 > UMBRAL_2 ||
        EDGES_C4 <= UMBRAL_2 || EDGES_C4 > MAX_EDGES ||
        P_C2 < 2 || P_C3 < 2 || P_C4 < 2) begin : g_param_check
        $error("generador_flancos: edge counts out of decode range or period below 2");
    end

    estado_t     r_state;
    logic        r_ready, r_busy, r_done, r_err, r_sensor;
    logic [7:0]  r_num, r_pidx, r_edges;
    logic [31:0] r_per, r_low, r_pcnt;

    logic        w_handshake, w_code_ok, w_start, w_active, w_last;
    logic [7:0]  w_num, w_pidx_nx;
    logic [31:0] w_per, w_low, w_pcnt_nx;
    logic        w_per_end, w_low_nx;

    assign w_handshake = i_code_valid & r_ready;
    assign w_start     = w_handshake & w_code_ok;

    always_comb begin
        w_code_ok = 1'b0;
        w_num     = '0;
        w_per     = '0;
        w_low     = '0;
        case (i_code_in)
            CODE_LOW: begin
                w_code_ok = 1'b1;
                w_num     = 8'(EDGES_C2);
                w_per     = 32'(P_C2);
                w_low     = 32'(L_C2);
            end
            CODE_MID: begin
                w_code_ok = 1'b1;
                w_num     = 8'(EDGES_C3);
                w_per     = 32'(P_C3);
                w_low     = 32'(L_C3);
            end
            CODE_HIGH: begin
                w_code_ok = 1'b1;
                w_num     = 8'(EDGES_C4);
                w_per     = 32'(P_C4);
                w_low     = 32'(L_C4);
            end
            default: ;
        endcase
    end

    // Next-cycle position inside the burst; pidx saturates once all N periods are done.
    always_comb begin
        w_per_end = (r_pcnt == r_per - 32'd1);
        w_pcnt_nx = w_per_end ? '0 : r_pcnt + 32'd1;
        w_pidx_nx = (w_per_end && r_pidx != r_num) ? r_pidx + 8'd1 : r_pidx;
        w_low_nx  = (w_pidx_nx < r_num) && (w_pcnt_nx < r_low) && w_active;
    end

    temporizador_ventana #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .o_active(w_active),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sensor <= 1'b1;
            r_num    <= '0;
            r_pidx   <= '0;
            r_edges  <= '0;
            r_per    <= '0;
            r_low    <= '0;
            r_pcnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_handshake) begin
                        if (w_code_ok) begin
                            // First fall lands on the first SEND cycle, so it is counted here.
                            r_state  <= StSend;
                            r_ready  <= 1'b0;
                            r_busy   <= 1'b1;
                            r_num    <= w_num;
                            r_per    <= w_per;
                            r_low    <= w_low;
                            r_pcnt   <= '0;
                            r_pidx   <= '0;
                            r_sensor <= 1'b0;
                            r_edges  <= 8'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (w_last) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_sensor <= 1'b1;
                    end else begin
                        r_pcnt   <= w_pcnt_nx;
                        r_pidx   <= w_pidx_nx;
                        r_sensor <= ~w_low_nx;
                        if (r_sensor && w_low_nx) begin
                            r_edges <= r_edges + 8'd1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_code_ready = r_ready;
    assign o_sensor_out = r_sensor;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_edges_sent = r_edges;

endmodule

// File: tb/tb_generador_flancos.sv
// Randomized bench for generador_flancos against a cycle-offset reference model.
module tb_generador_flancos;

    localparam int W = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       code_ready, sensor_out, busy, done, err;
    logic [7:0] edges_sent;

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_d is the cycle offset since the accepted transfer (1..W SEND, W+1 DONE).
    bit m_active = 0;
    int m_d = 0;
    int m_n = 0, m_p = 0, m_l = 0;
    bit m_err_pend = 0;
    bit prev_sensor = 1;
    int falls = 0;

    generador_flancos #(
        .WINDOW_CYCLES(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_code_in   (code_in),
        .i_code_valid(code_valid),
        .o_code_ready(code_ready),
        .o_sensor_out(sensor_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_edges_sent(edges_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int edges_for(input logic [2:0] c);
        case (c)
            3'd2:    return 10;
            3'd3:    return 23;
            3'd4:    return 40;
            default: return 0;
        endcase
    endfunction

    // One clock cycle: check outputs against the model, then apply this cycle's inputs.
    task automatic step(input logic v, input logic [2:0] c);
        bit s_exp, busy_exp, done_exp, ready_exp, err_exp;
        int w;
        @(negedge clk);
        s_exp = 1;
        if (m_active) begin
            if (m_d >= 1 && m_d <= W) begin
                w = m_d - 1;
                s_exp = !((w / m_p) < m_n && (w % m_p) < m_l);
            end
            busy_exp  = 1;
            done_exp  = (m_d == W + 1);
            ready_exp = 0;
            err_exp   = 0;
        end else begin
            busy_exp  = 0;
            done_exp  = 0;
            ready_exp = 1;
            err_exp   = m_err_pend;
        end
        chk("sensor_out", 32'(sensor_out), 32'(s_exp));
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("done", 32'(done), 32'(done_exp));
        chk("code_ready", 32'(code_ready), 32'(ready_exp));
        chk("err", 32'(err), 32'(err_exp));
        if (prev_sensor && !sensor_out) falls++;
        prev_sensor = sensor_out;
        if (m_active && m_d == W + 1) begin
            chk("falls_in_window", 32'(falls), 32'(m_n));
            chk("edges_sent", 32'(edges_sent), 32'(m_n));
        end
        code_valid = v;
        code_in    = c;
        if (m_active) begin
            m_d++;
            if (m_d > W + 1) m_active = 0;
        end
        m_err_pend = 0;
        if (ready_exp && v) begin
            if (edges_for(c) != 0) begin
                m_active = 1;
                m_d = 1;
                m_n = edges_for(c);
                m_p = W / m_n;
                m_l = m_p / 2;
                falls = 0;
            end else begin
                m_err_pend = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        code_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_sensor_out", 32'(sensor_out), 32'd1);
        chk("rst_code_ready", 32'(code_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_edges_sent", 32'(edges_sent), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_active = 0;
        m_err_pend = 0;
        prev_sensor = 1;
    endtask

    initial begin
        #12;
        chk("reset_sensor_out", 32'(sensor_out), 32'd1);
        chk("reset_code_ready", 32'(code_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_edges_sent", 32'(edges_sent), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Code 2 with an ignored code-4 request in the middle of the window.
        step(1'b1, 3'd2);
        idle(299);
        step(1'b1, 3'd4);
        idle(710);

        // Code 3 aborted by reset, then a fresh code 2.
        step(1'b1, 3'd3);
        idle(249);
        mid_reset();
        idle(2);
        step(1'b1, 3'd2);
        idle(1005);

        // Unsupported codes.
        step(1'b1, 3'd5);
        idle(2);
        step(1'b1, 3'd0);
        idle(2);
        step(1'b1, 3'd7);
        idle(2);

        step(1'b1, 3'd3);
        idle(1005);
        step(1'b1, 3'd4);
        idle(1005);

        // Back-to-back: valid held so each window starts the cycle ready returns.
        for (int i = 0; i < 2100; i++) step(1'b1, (i < 1000) ? 3'd4 : 3'd2);
        idle(1005);

        for (int i = 0; i < 8000; i++) begin
            if (m_active) step(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)));
            else          step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
        end
        idle(1010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
